// File: rtl/program_rom_loader_pkg.sv
// Shared definitions for the program ROM loader: loader FSM encoding and
// the width of the length field that prefixes a load image.
package program_rom_loader_pkg;

    localparam int LOAD_LEN_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN0 = 3'd1,
        ST_LEN1 = 3'd2,
        ST_DATA = 3'd3,
        ST_DONE = 3'd4
    } load_state_e;

    // States in which the loader accepts bytes from the receive stream.
    function automatic logic is_rx_state(input load_state_e s);
        return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA);
    endfunction

endpackage

// File: rtl/program_rom_loader_mem.sv
// Instruction storage: one write port and one registered read port.
// The array itself is never reset; only the read register is.
module inst_mem_array
    import program_rom_loader_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [31:0]       wdata_i,
    input  logic              rd_clr_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [2**ADDR_W];
    logic [31:0] rdata_d;
    logic [31:0] rdata_q;

    // Storage write port.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Next read data; forced to zero while the read side is held off.
    always_comb begin
        rdata_d = 32'h0000_0000;
        if (rd_clr_i) begin
            rdata_d = 32'h0000_0000;
        end else begin
            rdata_d = mem_q[raddr_i];
        end
    end

    // Registered read port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata_q <= 32'h0000_0000;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/program_rom_loader.sv
// Instruction ROM with a byte-stream loader: a length-prefixed image is
// written little-endian into the array while load_mode_i is high.
module program_rom_loader
    import program_rom_loader_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rom_adr_i,
    output logic [31:0]       Instruction_o,
    input  logic              load_mode_i,
    input  logic [7:0]        rx_byte_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic              load_done_o,
    output logic              load_err_o,
    output logic [15:0]       words_loaded_o
);

    load_state_e           state_d, state_q;
    logic [1:0]            byte_cnt_d, byte_cnt_q;
    logic [ADDR_W-1:0]     wr_adr_d, wr_adr_q;
    logic [LOAD_LEN_W-1:0] len_d, len_q;
    logic [15:0]           words_d, words_q;
    logic [23:0]           buf_d, buf_q;
    logic                  done_d, done_q;
    logic                  err_d, err_q;
    logic                  ready_d, ready_q;
    logic                  accept_s;
    logic                  in_range_s;
    logic                  we_s;
    logic [31:0]           wdata_s;

    assign accept_s   = rx_valid_i && ready_q && load_mode_i;
    // Word indices past the array depth are consumed but never written.
    assign in_range_s = ((words_q >> ADDR_W) == 16'd0);
    assign wdata_s    = {rx_byte_i, buf_q};

    // Loader next-state, byte assembly and write-strobe generation.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        wr_adr_d   = wr_adr_q;
        len_d      = len_q;
        words_d    = words_q;
        buf_d      = buf_q;
        done_d     = done_q;
        err_d      = err_q;
        we_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_mode_i) begin
                    state_d    = ST_LEN0;
                    byte_cnt_d = 2'd0;
                    wr_adr_d   = '0;
                    words_d    = 16'd0;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LEN0, ST_LEN1, ST_DATA: begin
                if (!load_mode_i) begin
                    state_d    = ST_IDLE;
                    byte_cnt_d = 2'd0;
                    err_d      = 1'b1;
                end else if (!accept_s) begin
                    state_d = state_q;
                end else if (state_q == ST_LEN0) begin
                    len_d[7:0] = rx_byte_i;
                    state_d    = ST_LEN1;
                end else if (state_q == ST_LEN1) begin
                    len_d[15:8] = rx_byte_i;
                    if ({rx_byte_i, len_q[7:0]} == 16'd0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else if (byte_cnt_q != 2'd3) begin
                    buf_d      = {rx_byte_i, buf_q[23:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                end else begin
                    byte_cnt_d = 2'd0;
                    words_d    = words_q + 16'd1;
                    if (in_range_s) begin
                        we_s     = 1'b1;
                        wr_adr_d = wr_adr_q + ADDR_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                    if ((words_q + 16'd1) == len_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DONE: begin
                if (!load_mode_i) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = is_rx_state(state_d);
    end

    // Loader state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= 2'd0;
            wr_adr_q   <= '0;
            len_q      <= '0;
            words_q    <= 16'd0;
            buf_q      <= 24'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            wr_adr_q   <= wr_adr_d;
            len_q      <= len_d;
            words_q    <= words_d;
            buf_q      <= buf_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
        end
    end

    inst_mem_array #(.ADDR_W(ADDR_W)) u_mem (
        .clock    (clock),
        .reset    (reset),
        .we_i     (we_s),
        .waddr_i  (wr_adr_q),
        .wdata_i  (wdata_s),
        .rd_clr_i (load_mode_i),
        .raddr_i  (rom_adr_i),
        .rdata_o  (Instruction_o)
    );

    assign rx_ready_o     = ready_q;
    assign load_done_o    = done_q;
    assign load_err_o     = err_q;
    assign words_loaded_o = words_q;

endmodule

// File: tb/tb_program_rom_loader.sv
// Scoreboard bench for program_rom_loader: a default-size instance and a
// four-word instance share stimulus; read-backs are checked against models.
module tb_program_rom_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic [13:0] rom_adr;
    logic        load_mode;
    logic [7:0]  rx_byte;
    logic        rx_valid;

    logic [31:0] instr_a, instr_b;
    logic        ready_a, done_a, err_a;
    logic        ready_b, done_b, err_b;
    logic [15:0] words_a, words_b;

    int total = 0;
    int bad   = 0;

    logic [31:0] model_a [int];
    logic [31:0] model_b [int];
    logic [31:0] exp_q_a [$];
    logic [31:0] exp_q_b [$];

    always #5 clock = ~clock;

    program_rom_loader #(.ADDR_W(14)) dut_a (
        .clock          (clock),
        .reset          (reset),
        .rom_adr_i      (rom_adr),
        .Instruction_o  (instr_a),
        .load_mode_i    (load_mode),
        .rx_byte_i      (rx_byte),
        .rx_valid_i     (rx_valid),
        .rx_ready_o     (ready_a),
        .load_done_o    (done_a),
        .load_err_o     (err_a),
        .words_loaded_o (words_a)
    );

    program_rom_loader #(.ADDR_W(2)) dut_b (
        .clock          (clock),
        .reset          (reset),
        .rom_adr_i      (rom_adr[1:0]),
        .Instruction_o  (instr_b),
        .load_mode_i    (load_mode),
        .rx_byte_i      (rx_byte),
        .rx_valid_i     (rx_valid),
        .rx_ready_o     (ready_b),
        .load_done_o    (done_b),
        .load_err_o     (err_b),
        .words_loaded_o (words_b)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        waited = 0;
        for (int g = 0; g < gap; g++) begin
            rx_byte  = 8'($urandom);
            rx_valid = 1'b0;
            step();
        end
        while (ready_a !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        if (ready_a !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL send_ready got=%b exp=1", ready_a);
        end
        rx_byte  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic start_load(input logic [15:0] len);
        load_mode = 1'b1;
        step();
        send_byte(len[7:0], 0);
        send_byte(len[15:8], 0);
    endtask

    task automatic send_word(input int idx, input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], gap);
        end
        if (idx < 16384) model_a[idx] = w;
        if (idx < 4) model_b[idx] = w;
    endtask

    task automatic read_check(input int addr);
        int  kb;
        logic chk_b;
        kb = addr % 4;
        rom_adr = 14'(addr);
        exp_q_a.push_back(model_a[addr]);
        chk_b = model_b.exists(kb);
        if (chk_b) exp_q_b.push_back(model_b[kb]);
        step();
        begin
            logic [31:0] e;
            e = exp_q_a.pop_front();
            total++;
            if (instr_a !== e) begin
                bad++;
                $display("FAIL read_a[%0d] got=%h exp=%h", addr, instr_a, e);
            end
            if (chk_b) begin
                e = exp_q_b.pop_front();
                total++;
                if (instr_b !== e) begin
                    bad++;
                    $display("FAIL read_b[%0d] got=%h exp=%h", kb, instr_b, e);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; load_mode = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; rom_adr = 14'd0;
        #12;
        total += 5;
        if (instr_a !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", instr_a); end
        if (ready_a !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", ready_a); end
        if (done_a !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done_a); end
        if (err_a !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err_a); end
        if (words_a !== 16'd0) begin bad++; $display("FAIL rst_words got=%0d exp=0", words_a); end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic_load();
        start_load(16'd2);
        send_word(0, 32'h0000_0013, 0);
        send_word(1, 32'h1234_5678, 0);
        total += 4;
        if (done_a !== 1'b1) begin bad++; $display("FAIL basic_done got=%b exp=1", done_a); end
        if (err_a !== 1'b0) begin bad++; $display("FAIL basic_err got=%b exp=0", err_a); end
        if (words_a !== 16'd2) begin bad++; $display("FAIL basic_words got=%0d exp=2", words_a); end
        if (ready_a !== 1'b0) begin bad++; $display("FAIL basic_ready got=%b exp=0", ready_a); end
        load_mode = 1'b0;
        step();
        read_check(1);
        read_check(0);
    endtask

    task automatic test_zero_len();
        start_load(16'd0);
        total += 3;
        if (done_a !== 1'b1) begin bad++; $display("FAIL zlen_done got=%b exp=1", done_a); end
        if (words_a !== 16'd0) begin bad++; $display("FAIL zlen_words got=%0d exp=0", words_a); end
        if (ready_a !== 1'b0) begin bad++; $display("FAIL zlen_ready got=%b exp=0", ready_a); end
        load_mode = 1'b0;
        step();
        total++;
        if (done_a !== 1'b0) begin bad++; $display("FAIL zlen_idle_done got=%b exp=0", done_a); end
        read_check(0);
        read_check(1);
    endtask

    task automatic test_overflow();
        logic [31:0] w;
        start_load(16'd5);
        for (int i = 0; i < 5; i++) begin
            w = 32'hA000_0000 + 32'(i * 32'h0101_0101);
            send_word(i, w, 0);
        end
        total += 5;
        if (err_b !== 1'b1) begin bad++; $display("FAIL ovf_err_b got=%b exp=1", err_b); end
        if (words_b !== 16'd5) begin bad++; $display("FAIL ovf_words_b got=%0d exp=5", words_b); end
        if (done_b !== 1'b1) begin bad++; $display("FAIL ovf_done_b got=%b exp=1", done_b); end
        if (err_a !== 1'b0) begin bad++; $display("FAIL ovf_err_a got=%b exp=0", err_a); end
        if (words_a !== 16'd5) begin bad++; $display("FAIL ovf_words_a got=%0d exp=5", words_a); end
        load_mode = 1'b0;
        step();
        for (int i = 0; i < 5; i++) read_check(i);
    endtask

    task automatic test_abort();
        start_load(16'd3);
        send_word(0, 32'h0BAD_C0DE, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        load_mode = 1'b0;
        step();
        total += 4;
        if (ready_a !== 1'b0) begin bad++; $display("FAIL abort_ready got=%b exp=0", ready_a); end
        if (err_a !== 1'b1) begin bad++; $display("FAIL abort_err got=%b exp=1", err_a); end
        if (words_a !== 16'd1) begin bad++; $display("FAIL abort_words got=%0d exp=1", words_a); end
        if (done_a !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", done_a); end
        read_check(0);
        read_check(1);
    endtask

    task automatic test_reset_mid_data();
        start_load(16'd2);
        send_word(0, 32'hFEED_BEEF, 0);
        send_byte(8'h77, 0);
        #2;
        reset = 1'b1;
        #1;
        total += 5;
        if (instr_a !== 32'h0) begin bad++; $display("FAIL mrst_instr got=%h exp=0", instr_a); end
        if (ready_a !== 1'b0) begin bad++; $display("FAIL mrst_ready got=%b exp=0", ready_a); end
        if (done_a !== 1'b0) begin bad++; $display("FAIL mrst_done got=%b exp=0", done_a); end
        if (err_a !== 1'b0) begin bad++; $display("FAIL mrst_err got=%b exp=0", err_a); end
        if (words_a !== 16'd0) begin bad++; $display("FAIL mrst_words got=%0d exp=0", words_a); end
        load_mode = 1'b0;
        step();
        reset = 1'b0;
        step();
        read_check(0);
        read_check(1);
    endtask

    task automatic test_gaps();
        for (int i = 0; i < 3; i++) begin
            rx_byte  = 8'h01;
            rx_valid = 1'b1;
            step();
        end
        rx_valid = 1'b0;
        total += 2;
        if (ready_a !== 1'b0) begin bad++; $display("FAIL idle_ready got=%b exp=0", ready_a); end
        if (words_a !== 16'd0) begin bad++; $display("FAIL idle_words got=%0d exp=0", words_a); end
        read_check(0);
        load_mode = 1'b1;
        step();
        total++;
        if (instr_a !== 32'h0) begin bad++; $display("FAIL loadmode_instr got=%h exp=0", instr_a); end
        send_byte(8'h01, 2);
        send_byte(8'h00, 1);
        send_word(0, 32'hCAFE_F00D, 2);
        total += 3;
        if (done_a !== 1'b1) begin bad++; $display("FAIL gap_done got=%b exp=1", done_a); end
        if (words_a !== 16'd1) begin bad++; $display("FAIL gap_words got=%0d exp=1", words_a); end
        if (err_a !== 1'b0) begin bad++; $display("FAIL gap_err got=%b exp=0", err_a); end
        load_mode = 1'b0;
        step();
        read_check(0);
        read_check(1);
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_zero_len();
        test_overflow();
        test_abort();
        test_reset_mid_data();
        test_gaps();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
